// File: rtl/bit_ser_pkg.sv
// Shared definitions for the serial bit deserializer and the future serializer.
// Holds the holding-register state type, the default word width and the counter width helper.
package bit_ser_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam int WIDTH_DEFAULT = 8;

   // Bits needed to count 0..w inclusive.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/bit_deserializer_sipo.sv
// Serial-in parallel-out shift register for the deserializer.
// clr discards the partial word; rst has priority over clr, and clr over shift_en.
module sipo_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_shift;

   // MSB-first shifts toward the MSB so the first bit ends in q[WIDTH-1];
   // LSB-first shifts toward the LSB so the first bit ends in q[0].
   always_comb begin
      q_shift = q;
      if (MSB_FIRST) begin
         q_shift = {q[WIDTH-2:0], din};
      end else begin
         q_shift = {din, q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (shift_en) begin
         q <= q_shift;
      end
   end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: gathers WIDTH valid bits into a word and offers it on a
// registered valid/ready port backed by a one-word holding register with sticky overrun.
module bit_deserializer
   import bit_ser_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEFAULT,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           din_valid,
   input  logic                           din,
   input  logic                           flush,
   output logic [WIDTH-1:0]               dout,
   output logic                           dout_valid,
   input  logic                           dout_ready,
   output logic                           overrun,
   output logic [cnt_width(WIDTH)-1:0]    bit_cnt
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // Output port handshake: a word moves to the consumer on any rising edge where
   // dout_valid=1 and dout_ready=1; dout is held constant at all other times while valid.

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] word_next;
   logic             complete;
   logic             shift_en;
   logic             shift_clr;
   logic             hold_load;
   logic             set_overrun;

   assign complete  = din_valid && !flush && (bit_cnt == LAST_BIT);
   assign shift_en  = din_valid && !flush;
   assign shift_clr = flush || complete;

   sipo_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_sipo (
      .clk      (clk),
      .rst      (rst),
      .clr      (shift_clr),
      .shift_en (shift_en),
      .din      (din),
      .q        (shift_q)
   );

   // The completed word includes the bit sampled on the completing edge.
   always_comb begin
      word_next = shift_q;
      if (MSB_FIRST) begin
         word_next = {shift_q[WIDTH-2:0], din};
      end else begin
         word_next = {din, shift_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
      end else if (flush) begin
         bit_cnt <= '0;
      end else if (complete) begin
         bit_cnt <= '0;
      end else if (din_valid) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      hold_load   = 1'b0;
      set_overrun = 1'b0;
      case (state)
         EMPTY: begin
            if (complete) begin
               hold_load  = 1'b1;
               state_next = FULL;
            end
         end
         FULL: begin
            if (complete) begin
               // A word arriving while full survives only if the old one leaves now.
               if (dout_ready) begin
                  hold_load = 1'b1;
               end else begin
                  set_overrun = 1'b1;
               end
            end else if (dout_ready) begin
               state_next = EMPTY;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else if (hold_load) begin
         dout <= word_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (set_overrun) begin
         overrun <= 1'b1;
      end
   end

   assign dout_valid = (state == FULL);

endmodule

// File: tb/tb_bit_deserializer.sv
// Bench for bit_deserializer: MSB-first and LSB-first instances share one stimulus
// stream and are compared every cycle against a bit-queue reference model.
module tb_bit_deserializer;

   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          din_valid = 1'b0;
   logic          din = 1'b0;
   logic          flush = 1'b0;
   logic          dout_ready = 1'b0;
   logic [W-1:0]  dout_m, dout_l;
   logic          valid_m, valid_l;
   logic          ovr_m, ovr_l;
   logic [CW-1:0] cnt_m, cnt_l;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit           bq[$];
   logic [W-1:0] m_dout_m, m_dout_l;
   logic         m_valid, m_ovr;

   typedef struct {
      logic [W-1:0] sent;   // bits sent sent[7] first
      logic [W-1:0] exp_m;
      logic [W-1:0] exp_l;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .flush(flush),
      .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
      .overrun(ovr_m), .bit_cnt(cnt_m)
   );

   bit_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .flush(flush),
      .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
      .overrun(ovr_l), .bit_cnt(cnt_l)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Applies the rules for one rising edge using the inputs currently driven.
   task automatic model_edge();
      bit           completed;
      logic [W-1:0] wm, wl;
      completed = 1'b0;
      wm = '0;
      wl = '0;
      if (rst) begin
         bq.delete();
         m_dout_m = '0;
         m_dout_l = '0;
         m_valid  = 1'b0;
         m_ovr    = 1'b0;
      end else begin
         if (flush) begin
            bq.delete();
         end else if (din_valid) begin
            bq.push_back(din);
            if (bq.size() == W) begin
               for (int i = 0; i < W; i++) begin
                  wm = wm + (W'(bq[i]) << (W - 1 - i));
                  wl = wl + (W'(bq[i]) << i);
               end
               bq.delete();
               completed = 1'b1;
            end
         end
         if (completed) begin
            if (!m_valid || dout_ready) begin
               m_dout_m = wm;
               m_dout_l = wl;
               m_valid  = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && dout_ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      check("dout_msb", 32'(dout_m), 32'(m_dout_m));
      check("dout_lsb", 32'(dout_l), 32'(m_dout_l));
      check("valid_msb", 32'(valid_m), 32'(m_valid));
      check("valid_lsb", 32'(valid_l), 32'(m_valid));
      check("overrun_msb", 32'(ovr_m), 32'(m_ovr));
      check("overrun_lsb", 32'(ovr_l), 32'(m_ovr));
      check("bit_cnt_msb", 32'(cnt_m), 32'(bq.size()));
      check("bit_cnt_lsb", 32'(cnt_l), 32'(bq.size()));
   endtask

   task automatic step(input logic v, input logic d, input logic f = 1'b0,
                       input logic rd = 1'b0, input logic r = 1'b0);
      din_valid  = v;
      din        = d;
      flush      = f;
      dout_ready = rd;
      rst        = r;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic rd = 1'b0);
      for (int i = W - 1; i >= 0; i--) begin
         step(1'b1, w[i], 1'b0, rd);
      end
   endtask

   task automatic check_outs(input string tag, input logic [W-1:0] em, input logic [W-1:0] el,
                             input logic ev, input logic eo, input int ec);
      check({tag, "_dout_msb"}, 32'(dout_m), 32'(em));
      check({tag, "_dout_lsb"}, 32'(dout_l), 32'(el));
      check({tag, "_valid"}, 32'(valid_m), 32'(ev));
      check({tag, "_overrun"}, 32'(ovr_m), 32'(eo));
      check({tag, "_bit_cnt"}, 32'(cnt_m), 32'(ec));
   endtask

   initial begin
      vecs[0] = '{8'hB2, 8'hB2, 8'h4D};
      vecs[1] = '{8'hA5, 8'hA5, 8'hA5};
      vecs[2] = '{8'h3C, 8'h3C, 8'h3C};
      vecs[3] = '{8'hFF, 8'hFF, 8'hFF};
      vecs[4] = '{8'h00, 8'h00, 8'h00};
      vecs[5] = '{8'h81, 8'h81, 8'h81};
      vecs[6] = '{8'h69, 8'h69, 8'h96};
      vecs[7] = '{8'h01, 8'h01, 8'h80};

      m_dout_m = '0;
      m_dout_l = '0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;

      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0, 0);

      // Single words in both bit orders, consumed after each.
      for (int k = 0; k < 8; k++) begin
         send_word(vecs[k].sent);
         check_outs($sformatf("vec%0d", k), vecs[k].exp_m, vecs[k].exp_l, 1'b1, 1'b0, 0);
         step(0, 0, 0, 1);
         check($sformatf("vec%0d_consumed", k), 32'(valid_m), 32'd0);
      end

      // Back-to-back words with ready held high.
      send_word(8'hA5, 1'b1);
      check_outs("b2b_first", 8'hA5, 8'hA5, 1'b1, 1'b0, 0);
      send_word(8'h3C, 1'b1);
      check_outs("b2b_second", 8'h3C, 8'h3C, 1'b1, 1'b0, 0);
      step(0, 0, 0, 1);
      check("b2b_drained", 32'(valid_m), 32'd0);

      // Partial word discarded by flush, including a valid bit on the flush edge.
      send_word(8'hF0);
      step(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 1);
      check("pre_flush_cnt", 32'(cnt_m), 32'd4);
      step(1, 1, 1);
      check("flush_cnt", 32'(cnt_m), 32'd0);
      send_word(8'h81);
      check_outs("flush_word", 8'h81, 8'h81, 1'b1, 1'b0, 0);
      step(0, 0, 0, 1);

      // Overrun under back-pressure, then drain.
      send_word(8'hFF);
      send_word(8'h00);
      check_outs("overrun", 8'hFF, 8'hFF, 1'b1, 1'b1, 0);
      step(0, 0, 0, 1);
      check_outs("overrun_drain", 8'hFF, 8'hFF, 1'b0, 1'b1, 0);

      // Reset mid-word and while full.
      for (int i = 0; i < 5; i++) step(1, i[0]);
      step(0, 0, 0, 0, 1);
      check_outs("rst_midword", 8'h00, 8'h00, 1'b0, 1'b0, 0);
      send_word(8'hC3);
      step(1, 1);
      step(1, 0, 0, 0, 1);
      check_outs("rst_full", 8'h00, 8'h00, 1'b0, 1'b0, 0);
      send_word(8'h5A);
      check_outs("rst_clean", 8'h5A, 8'h5A, 1'b1, 1'b0, 0);
      step(0, 0, 0, 1);

      // Idle cycles interleaved, then ready raised exactly on the next completing edge.
      begin
         logic [W-1:0] w69;
         logic [W-1:0] w2;
         w69 = 8'h69;
         w2  = 8'hD4;
         for (int i = W - 1; i >= 0; i--) begin
            int idles;
            idles = $urandom_range(0, 3);
            for (int j = 0; j < idles; j++) step(0, $urandom_range(0, 1));
            step(1, w69[i]);
         end
         check_outs("idle_word", 8'h69, 8'h96, 1'b1, 1'b0, 0);
         for (int i = W - 1; i >= 1; i--) begin
            step(0, 0);
            step(1, w2[i]);
         end
         step(1, w2[0], 0, 1);
         check_outs("ready_on_complete", 8'hD4, 8'h2B, 1'b1, 1'b0, 0);
         step(0, 0, 0, 1);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 2) != 0, $urandom_range(0, 1),
              $urandom_range(0, 19) == 0, $urandom_range(0, 1),
              $urandom_range(0, 299) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
